// File: rtl/adder_pkg.sv
// Shared definitions for the ripple-carry adder and the datapath blocks that consume it.
package adder_pkg;

    localparam int unsigned ADDER_WIDTH = 32;

    // Full (ADDER_WIDTH+1)-bit unsigned result as a consumer sees it.
    typedef struct packed {
        logic                   carry;
        logic [ADDER_WIDTH-1:0] sum;
    } adder_result_t;

endpackage

// File: rtl/fulladder_bit.sv
// One full-adder cell; chained by adder32 to form the ripple-carry core.
module fulladder_bit (
    input  logic a,
    input  logic b,
    input  logic c,
    output logic s,
    output logic co
);

    assign s  = a ^ b ^ c;
    assign co = (a & b) | (a & c) | (b & c);

endmodule

// File: rtl/adder32.sv
// Registered ripple-carry adder: {carry_o, sum_o} = a_i + b_i + carry_i, one cycle after valid_i.
module adder32
    import adder_pkg::*;
#(
    parameter int unsigned WIDTH = ADDER_WIDTH
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             valid_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             carry_i,
    output logic             valid_o,
    output logic [WIDTH-1:0] sum_o,
    output logic             carry_o
);

    logic [WIDTH:0]   carry_chain;
    logic [WIDTH-1:0] sum_comb;

    assign carry_chain[0] = carry_i;

    for (genvar k = 0; k < WIDTH; k++) begin : g_stage
        fulladder_bit u_fa (
            .a  (a_i[k]),
            .b  (b_i[k]),
            .c  (carry_chain[k]),
            .s  (sum_comb[k]),
            .co (carry_chain[k+1])
        );
    end

    // Result only loads on valid_i, so garbage on idle operands never reaches sum_o.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_o <= 1'b0;
            sum_o   <= '0;
            carry_o <= 1'b0;
        end else begin
            valid_o <= valid_i;
            if (valid_i) begin
                sum_o   <= sum_comb;
                carry_o <= carry_chain[WIDTH];
            end
        end
    end

endmodule

// File: tb/tb_adder32.sv
// Self-checking bench for adder32: directed cases plus a back-to-back random run against a scoreboard.
module tb_adder32;

    localparam int W = 32;

    logic         clk_i   = 1'b0;
    logic         rst_ni  = 1'b1;
    logic         valid_i = 1'b0;
    logic [W-1:0] a_i     = '0;
    logic [W-1:0] b_i     = '0;
    logic         carry_i = 1'b0;
    logic         valid_o;
    logic [W-1:0] sum_o;
    logic         carry_o;

    int total = 0;
    int bad   = 0;

    logic [W:0] exp_q[$];
    logic [W:0] exp_v;

    always #5 clk_i = ~clk_i;

    adder32 #(.WIDTH(W)) dut (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .valid_i (valid_i),
        .a_i     (a_i),
        .b_i     (b_i),
        .carry_i (carry_i),
        .valid_o (valid_o),
        .sum_o   (sum_o),
        .carry_o (carry_o)
    );

    task automatic drive_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
        @(negedge clk_i);
        valid_i = 1'b1;
        a_i     = a;
        b_i     = b;
        carry_i = c;
        exp_q.push_back({1'b0, a} + {1'b0, b} + {{W{1'b0}}, c});
    endtask

    task automatic test_reset;
        #1 rst_ni = 1'b0;
        #1;
        total++;
        if (valid_o !== 1'b0 || carry_o !== 1'b0 || sum_o !== '0) begin
            bad++;
            $display("FAIL reset_initial: got v=%b c=%b s=%h want all zero", valid_o, carry_o, sum_o);
        end
        @(negedge clk_i);
        rst_ni = 1'b1;

        drive_op(32'h8000_0001, 32'h8000_0002, 1'b1);
        @(posedge clk_i); #1;
        exp_v = exp_q.pop_front();
        total++;
        if (valid_o !== 1'b1 || {carry_o, sum_o} !== exp_v) begin
            bad++;
            $display("FAIL pre_reset_op: got v=%b %h want v=1 %h", valid_o, {carry_o, sum_o}, exp_v);
        end

        // Second op in flight when reset hits between edges
        drive_op(32'h1234_5678, 32'h1111_1111, 1'b0);
        #2 rst_ni = 1'b0;
        #1;
        total++;
        if (valid_o !== 1'b0 || carry_o !== 1'b0 || sum_o !== '0) begin
            bad++;
            $display("FAIL reset_async: got v=%b c=%b s=%h want all zero", valid_o, carry_o, sum_o);
        end
        exp_q.delete();
        @(posedge clk_i); #1;
        total++;
        if (valid_o !== 1'b0 || carry_o !== 1'b0 || sum_o !== '0) begin
            bad++;
            $display("FAIL reset_held: got v=%b c=%b s=%h want all zero", valid_o, carry_o, sum_o);
        end
        #1 rst_ni = 1'b1;

        drive_op(32'h0000_0010, 32'h0000_0020, 1'b1);
        @(posedge clk_i); #1;
        exp_v = exp_q.pop_front();
        total++;
        if (valid_o !== 1'b1 || {carry_o, sum_o} !== exp_v || exp_v !== 33'h31) begin
            bad++;
            $display("FAIL first_after_reset: got v=%b %h want v=1 %h", valid_o, {carry_o, sum_o}, 33'h31);
        end
    endtask

    task automatic test_basic;
        drive_op(32'd37, 32'd58, 1'b1);
        @(posedge clk_i); #1;
        exp_v = exp_q.pop_front();
        total++;
        if (valid_o !== 1'b1 || {carry_o, sum_o} !== 33'd96) begin
            bad++;
            $display("FAIL basic_add: got v=%b %0d want v=1 96", valid_o, {carry_o, sum_o});
        end
    endtask

    task automatic test_overflow;
        drive_op(32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
        @(posedge clk_i); #1;
        exp_v = exp_q.pop_front();
        total++;
        if (valid_o !== 1'b1 || carry_o !== 1'b1 || sum_o !== 32'h0) begin
            bad++;
            $display("FAIL overflow_wrap: got v=%b c=%b s=%h want v=1 c=1 s=00000000", valid_o, carry_o, sum_o);
        end
        drive_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
        @(posedge clk_i); #1;
        exp_v = exp_q.pop_front();
        total++;
        if (valid_o !== 1'b1 || carry_o !== 1'b1 || sum_o !== 32'hFFFF_FFFF) begin
            bad++;
            $display("FAIL overflow_max: got v=%b c=%b s=%h want v=1 c=1 s=ffffffff", valid_o, carry_o, sum_o);
        end
        drive_op(32'h0, 32'h0, 1'b0);
        @(posedge clk_i); #1;
        exp_v = exp_q.pop_front();
        total++;
        if (valid_o !== 1'b1 || carry_o !== 1'b0 || sum_o !== 32'h0) begin
            bad++;
            $display("FAIL all_zero: got v=%b c=%b s=%h want v=1 c=0 s=00000000", valid_o, carry_o, sum_o);
        end
    endtask

    task automatic test_carry_prop;
        drive_op(32'h7FFF_FFFF, 32'h0, 1'b1);
        @(posedge clk_i); #1;
        exp_v = exp_q.pop_front();
        total++;
        if (valid_o !== 1'b1 || carry_o !== 1'b0 || sum_o !== 32'h8000_0000) begin
            bad++;
            $display("FAIL carry_prop: got v=%b c=%b s=%h want v=1 c=0 s=80000000", valid_o, carry_o, sum_o);
        end
    endtask

    task automatic test_hold;
        drive_op(32'd37, 32'd58, 1'b1);
        @(posedge clk_i); #1;
        exp_v = exp_q.pop_front();
        total++;
        if (valid_o !== 1'b1 || {carry_o, sum_o} !== 33'd96) begin
            bad++;
            $display("FAIL hold_setup: got v=%b %0d want v=1 96", valid_o, {carry_o, sum_o});
        end
        @(negedge clk_i);
        valid_i = 1'b0;
        a_i     = 32'd5;
        b_i     = 32'd5;
        @(posedge clk_i); #1;
        total++;
        if (valid_o !== 1'b0 || {carry_o, sum_o} !== 33'd96) begin
            bad++;
            $display("FAIL hold_idle: got v=%b %0d want v=0 96", valid_o, {carry_o, sum_o});
        end
        @(negedge clk_i);
        a_i     = 'x;
        b_i     = 'z;
        carry_i = 1'bx;
        @(posedge clk_i); #1;
        total++;
        if (valid_o !== 1'b0 || {carry_o, sum_o} !== 33'd96) begin
            bad++;
            $display("FAIL hold_xz: got v=%b %h want v=0 96", valid_o, {carry_o, sum_o});
        end
        @(negedge clk_i);
        a_i     = '0;
        b_i     = '0;
        carry_i = 1'b0;
    endtask

    task automatic test_back_to_back;
        for (int i = 0; i < 100; i++) begin
            drive_op(W'($urandom_range(0, 99)), W'($urandom_range(0, 99)), 1'($urandom_range(0, 1)));
            @(posedge clk_i); #1;
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL rand_%0d: scoreboard empty with v=%b", i, valid_o);
            end else begin
                exp_v = exp_q.pop_front();
                if (valid_o !== 1'b1 || {carry_o, sum_o} !== exp_v) begin
                    bad++;
                    $display("FAIL rand_%0d: got v=%b %h want v=1 %h", i, valid_o, {carry_o, sum_o}, exp_v);
                end
            end
        end
        @(negedge clk_i);
        valid_i = 1'b0;
        @(posedge clk_i); #1;
        total++;
        if (valid_o !== 1'b0 || exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain: got v=%b pending=%0d want v=0 pending=0", valid_o, exp_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_overflow();
        test_carry_prop();
        test_hold();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
